// File: rtl/sync_to_count_if.sv
// sync_to_count_if
// Groups the sync inputs and the coordinate/status outputs of sync_to_count.
//   master : drives H_pulse/V_pulse and observes the outputs (the generator side / bench)
//   slave  : the sync_to_count block itself
// Signals:
//   H_pulse, V_pulse      active-low sync from the VGA sync generator
//   COL, ROW              rebuilt pixel coordinates
//   ACTIVE                visible-area qualifier (only while locked)
//   H_SYNC_O, V_SYNC_O    syncs re-timed to COL/ROW
//   LOCKED, FRAME_START   lock status, start-of-frame pulse
//   SYNC_ERR              one-cycle lock-violation pulse
interface sync_to_count_if;
   logic       H_pulse;
   logic       V_pulse;
   logic [9:0] COL;
   logic [9:0] ROW;
   logic       ACTIVE;
   logic       H_SYNC_O;
   logic       V_SYNC_O;
   logic       LOCKED;
   logic       FRAME_START;
   logic       SYNC_ERR;

   modport master (
      output H_pulse, V_pulse,
      input  COL, ROW, ACTIVE, H_SYNC_O, V_SYNC_O, LOCKED, FRAME_START, SYNC_ERR
   );

   modport slave (
      input  H_pulse, V_pulse,
      output COL, ROW, ACTIVE, H_SYNC_O, V_SYNC_O, LOCKED, FRAME_START, SYNC_ERR
   );
endinterface

// File: rtl/sync_to_count.sv
// sync_to_count
// Rebuilds COL/ROW pixel coordinates from the active-low H/V sync pair of the
// VGA sync generator, re-times the syncs to the coordinates and tracks lock.
// A free-running counter pair predicts where each sync edge should land; a
// three-state machine (UNLOCKED -> H_ALIGNED -> LOCKED) compares real edges
// against those predictions.
// Ports:
//   CLK    pixel clock (same clock as the sync generator)
//   RST_N  asynchronous active-low reset
//   sif    sync_to_count_if.slave: H_pulse/V_pulse in; COL, ROW, ACTIVE,
//          H_SYNC_O, V_SYNC_O, LOCKED, FRAME_START, SYNC_ERR out (all registered)
module sync_to_count #(
   parameter int H_TOTAL  = 800,
   parameter int V_TOTAL  = 525,
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int H_FRONT  = 16,
   parameter int V_FRONT  = 10
) (
   input  logic           CLK,
   input  logic           RST_N,
   sync_to_count_if.slave sif
);

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_SYNC = 10'(H_ACTIVE + H_FRONT);
   localparam logic [9:0] V_SYNC = 10'(V_ACTIVE + V_FRONT);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);

   typedef enum logic [1:0] {UNLOCKED, H_ALIGNED, LOCKED} state_t;

   state_t     state_q, state_d;
   logic [9:0] col_q, col_d;
   logic [9:0] row_q, row_d;
   logic       h_d_q, v_d_q;   // previous sync samples, doubling as H_SYNC_O/V_SYNC_O
   logic       active_q, active_d;
   logic       fs_q, fs_d;
   logic       err_q, err_d;

   logic       hfall, vfall;
   logic       col_wrap, hexp, vexp;
   logic       h_miss, v_miss, h_bad, v_bad;
   logic [9:0] col_fr, row_fr;

   // Counters: free-running prediction plus edge reloads
   always_comb begin
      hfall    = h_d_q & ~sif.H_pulse;
      vfall    = v_d_q & ~sif.V_pulse;
      col_wrap = (col_q == H_LAST);
      col_fr   = col_wrap ? '0 : col_q + 10'd1;
      row_fr   = row_q;
      if (col_wrap)
         row_fr = (row_q == V_LAST) ? '0 : row_q + 10'd1;
      hexp     = (col_fr == H_SYNC);
      vexp     = col_wrap && (row_fr == V_SYNC);

      col_d    = hfall ? H_SYNC : col_fr;
      // A reloading H edge means the column did not actually wrap.
      row_d    = vfall ? V_SYNC : (hfall ? row_q : row_fr);
   end

   // Lock machine
   always_comb begin
      state_d = state_q;
      err_d   = 1'b0;
      h_miss  = hexp & ~hfall;
      v_miss  = vexp & ~vfall;
      h_bad   = hfall & ~hexp;
      v_bad   = vfall & ~vexp;
      case (state_q)
         UNLOCKED:  if (hfall) state_d = H_ALIGNED;
         H_ALIGNED: if (vfall) state_d = LOCKED;
         LOCKED: begin
            // A missing edge outranks a misplaced one when both occur.
            if (h_miss || v_miss) begin
               state_d = UNLOCKED;
               err_d   = 1'b1;
            end else if (h_bad || v_bad) begin
               state_d = H_ALIGNED;
               err_d   = 1'b1;
            end
         end
         default:   state_d = UNLOCKED;
      endcase
      // Qualifiers look at next-state values so they line up with COL/ROW.
      active_d = (state_d == LOCKED) && (col_d < H_ACT) && (row_d < V_ACT);
      fs_d     = (state_d == LOCKED) && (col_d == '0) && (row_d == '0);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= UNLOCKED;
         col_q    <= '0;
         row_q    <= '0;
         h_d_q    <= 1'b1;
         v_d_q    <= 1'b1;
         active_q <= 1'b0;
         fs_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         row_q    <= row_d;
         h_d_q    <= sif.H_pulse;
         v_d_q    <= sif.V_pulse;
         active_q <= active_d;
         fs_q     <= fs_d;
         err_q    <= err_d;
      end
   end

   assign sif.COL         = col_q;
   assign sif.ROW         = row_q;
   assign sif.H_SYNC_O    = h_d_q;
   assign sif.V_SYNC_O    = v_d_q;
   assign sif.ACTIVE      = active_q;
   assign sif.LOCKED      = (state_q == LOCKED);
   assign sif.FRAME_START = fs_q;
   assign sif.SYNC_ERR    = err_q;

endmodule

// File: tb/tb_sync_to_count.sv
// tb_sync_to_count
// Directed bench for sync_to_count using a reduced 40x20 raster so whole
// frames fit in a short run. A small sync generator model (gc/gr counters)
// drives H_pulse/V_pulse and can stretch or drop one line's H pulse.
module tb_sync_to_count;

   localparam int HT = 40;
   localparam int VT = 20;
   localparam int HA = 24;
   localparam int VA = 12;
   localparam int HF = 4;
   localparam int VF = 3;
   localparam int HS = HA + HF;   // 28
   localparam int VS = VA + VF;   // 15
   localparam int HW = 6;         // H sync width
   localparam int VW = 2;         // V sync width (lines)
   localparam int FT = HT * VT;   // 800 clocks per frame

   logic CLK   = 1'b0;
   logic RST_N = 1'b1;

   sync_to_count_if sif ();

   sync_to_count #(
      .H_TOTAL (HT), .V_TOTAL (VT), .H_ACTIVE(HA),
      .V_ACTIVE(VA), .H_FRONT (HF), .V_FRONT (VF)
   ) dut (
      .CLK  (CLK),
      .RST_N(RST_N),
      .sif  (sif.slave)
   );

   always #20 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // generator state
   int gc = 0, gr = 0;
   bit mod_en = 0, mod_sup = 0;
   int mod_shift = 0, mod_row = 0;

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One generator clock: present syncs, take an edge, sample #1 later.
   task automatic step();
      int  hs;
      bit  hlow;
      hs = HS;
      if (mod_en && gr == mod_row) hs = HS + mod_shift;
      hlow = (gc >= hs) && (gc < HS + HW);
      if (mod_en && mod_sup && gr == mod_row) hlow = 1'b0;
      sif.H_pulse = !hlow;
      sif.V_pulse = !((gr >= VS) && (gr < VS + VW));
      @(posedge CLK);
      #1;
      if (gc == HT - 1) begin
         gc = 0;
         gr = (gr == VT - 1) ? 0 : gr + 1;
      end else begin
         gc = gc + 1;
      end
   endtask

   task automatic test_reset();
      sif.H_pulse = 1'b1;
      sif.V_pulse = 1'b1;
      #5 RST_N = 1'b0;
      repeat (5) @(posedge CLK);
      #1;
      checks++;
      if (sif.COL !== 10'd0 || sif.ROW !== 10'd0) begin
         errors++;
         $display("FAIL reset_coords: COL=%0d ROW=%0d expected 0/0", sif.COL, sif.ROW);
      end
      checks++;
      if ({sif.ACTIVE, sif.LOCKED, sif.FRAME_START, sif.SYNC_ERR, sif.H_SYNC_O, sif.V_SYNC_O} !== 6'b000011) begin
         errors++;
         $display("FAIL reset_flags: {ACT,LCK,FS,ERR,HS,VS}=%b expected 000011",
                  {sif.ACTIVE, sif.LOCKED, sif.FRAME_START, sif.SYNC_ERR, sif.H_SYNC_O, sif.V_SYNC_O});
      end
      RST_N = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(posedge CLK);
         #1;
         checks++;
         if (sif.COL !== 10'(i) || sif.ROW !== 10'd0 || sif.LOCKED !== 1'b0) begin
            errors++;
            $display("FAIL release_count: COL=%0d ROW=%0d LOCKED=%0d expected %0d/0/0",
                     sif.COL, sif.ROW, sif.LOCKED, i);
         end
      end
   endtask

   task automatic test_acquire();
      int n, errs, act, fs, unl, pc, pr, ec, er;
      gc = 0; gr = 0;
      n = 0;
      while (sif.H_SYNC_O !== 1'b0 && n < 2 * FT) begin step(); n++; end
      checks++;
      if (sif.H_SYNC_O !== 1'b0 || sif.COL !== 10'(HS)) begin
         errors++;
         $display("FAIL first_hsync: H_SYNC_O=%0d COL=%0d expected 0/%0d", sif.H_SYNC_O, sif.COL, HS);
      end
      n = 0; errs = 0;
      while (sif.LOCKED !== 1'b1 && n < 2 * FT) begin
         step(); n++;
         if (sif.SYNC_ERR === 1'b1) errs++;
      end
      checks++;
      if (sif.LOCKED !== 1'b1 || sif.ROW !== 10'(VS) || sif.COL !== 10'd0 || sif.V_SYNC_O !== 1'b0) begin
         errors++;
         $display("FAIL lock_point: LOCKED=%0d ROW=%0d COL=%0d V_SYNC_O=%0d expected 1/%0d/0/0",
                  sif.LOCKED, sif.ROW, sif.COL, sif.V_SYNC_O, VS);
      end
      n = 0;
      while (sif.FRAME_START !== 1'b1 && n < FT) begin
         step(); n++;
         if (sif.SYNC_ERR === 1'b1) errs++;
      end
      checks++;
      if (n !== (VT - VS) * HT) begin
         errors++;
         $display("FAIL first_frame_start: after %0d clocks expected %0d", n, (VT - VS) * HT);
      end
      act = 0; fs = 0; unl = 0;
      for (int i = 0; i < 3 * FT; i++) begin
         pc = int'(sif.COL);
         pr = int'(sif.ROW);
         step();
         ec = (pc == HT - 1) ? 0 : pc + 1;
         er = (pc == HT - 1) ? ((pr == VT - 1) ? 0 : pr + 1) : pr;
         checks++;
         if (sif.COL !== 10'(ec) || sif.ROW !== 10'(er)) begin
            errors++;
            if (errors < 20)
               $display("FAIL count_seq: COL=%0d ROW=%0d expected %0d/%0d", sif.COL, sif.ROW, ec, er);
         end
         checks++;
         if (sif.ACTIVE !== ((ec < HA) && (er < VA)) ||
             sif.FRAME_START !== ((ec == 0) && (er == 0)) ||
             sif.H_SYNC_O !== !((ec >= HS) && (ec < HS + HW)) ||
             sif.V_SYNC_O !== !((er >= VS) && (er < VS + VW))) begin
            errors++;
            if (errors < 20)
               $display("FAIL qualifiers: at COL=%0d ROW=%0d ACT=%0d FS=%0d HS=%0d VS=%0d",
                        ec, er, sif.ACTIVE, sif.FRAME_START, sif.H_SYNC_O, sif.V_SYNC_O);
         end
         if (sif.ACTIVE === 1'b1) act++;
         if (sif.FRAME_START === 1'b1) fs++;
         if (sif.SYNC_ERR === 1'b1) errs++;
         if (sif.LOCKED !== 1'b1) unl++;
      end
      checks++;
      if (act !== 3 * HA * VA) begin
         errors++;
         $display("FAIL active_count: %0d clocks expected %0d", act, 3 * HA * VA);
      end
      checks++;
      if (fs !== 3) begin
         errors++;
         $display("FAIL frame_start_count: %0d expected 3", fs);
      end
      checks++;
      if (errs !== 0 || unl !== 0) begin
         errors++;
         $display("FAIL nominal_errs: SYNC_ERR=%0d unlocked=%0d expected 0/0", errs, unl);
      end
   endtask

   task automatic test_wrap();
      int n;
      n = 0;
      while (!(sif.COL === 10'(HT - 1) && sif.ROW === 10'(VT - 1)) && n < FT) begin step(); n++; end
      step();
      checks++;
      if (sif.COL !== 10'd0 || sif.ROW !== 10'd0 || sif.FRAME_START !== 1'b1) begin
         errors++;
         $display("FAIL frame_wrap: COL=%0d ROW=%0d FS=%0d expected 0/0/1", sif.COL, sif.ROW, sif.FRAME_START);
      end
      step();
      checks++;
      if (sif.COL !== 10'd1 || sif.FRAME_START !== 1'b0) begin
         errors++;
         $display("FAIL frame_start_width: COL=%0d FS=%0d expected 1/0", sif.COL, sif.FRAME_START);
      end
   endtask

   task automatic test_line_stretch();
      int n, errs;
      n = 0;
      while (!(gc == 0 && gr == 4) && n < FT) begin step(); n++; end
      mod_row = 4; mod_shift = 4; mod_sup = 0; mod_en = 1;
      n = 0;
      while (sif.SYNC_ERR !== 1'b1 && n < 2 * HT) begin step(); n++; end
      checks++;
      if ({sif.SYNC_ERR, sif.LOCKED, sif.ACTIVE} !== 3'b100 || sif.COL !== 10'(HS) || sif.ROW !== 10'd4) begin
         errors++;
         $display("FAIL stretch_err: {ERR,LCK,ACT}=%b COL=%0d ROW=%0d expected 100/%0d/4",
                  {sif.SYNC_ERR, sif.LOCKED, sif.ACTIVE}, sif.COL, sif.ROW, HS);
      end
      step();
      checks++;
      if (sif.SYNC_ERR !== 1'b0 || sif.COL !== 10'(HS + 1)) begin
         errors++;
         $display("FAIL stretch_err_width: ERR=%0d COL=%0d expected 0/%0d", sif.SYNC_ERR, sif.COL, HS + 1);
      end
      repeat (3) step();
      checks++;
      if (sif.COL !== 10'(HS) || sif.H_SYNC_O !== 1'b0 || sif.LOCKED !== 1'b0) begin
         errors++;
         $display("FAIL stretch_reload: COL=%0d H_SYNC_O=%0d LOCKED=%0d expected %0d/0/0",
                  sif.COL, sif.H_SYNC_O, sif.LOCKED, HS);
      end
      n = 0; errs = 0;
      while (gr == 4 && n < HT) begin step(); n++; if (sif.SYNC_ERR === 1'b1) errs++; end
      mod_en = 0;
      n = 0;
      while (sif.LOCKED !== 1'b1 && n < 2 * FT) begin
         step(); n++;
         if (sif.SYNC_ERR === 1'b1) errs++;
      end
      checks++;
      if (sif.LOCKED !== 1'b1 || sif.ROW !== 10'(VS) || errs !== 0) begin
         errors++;
         $display("FAIL stretch_relock: LOCKED=%0d ROW=%0d extra_errs=%0d expected 1/%0d/0",
                  sif.LOCKED, sif.ROW, errs, VS);
      end
   endtask

   task automatic test_missing_pulse();
      int n, errs;
      n = 0;
      while (!(gc == 0 && gr == 6) && n < FT) begin step(); n++; end
      mod_row = 6; mod_shift = 0; mod_sup = 1; mod_en = 1;
      n = 0;
      while (sif.SYNC_ERR !== 1'b1 && n < 2 * HT) begin step(); n++; end
      checks++;
      if (sif.SYNC_ERR !== 1'b1 || sif.LOCKED !== 1'b0 || sif.COL !== 10'(HS) || sif.ROW !== 10'd6) begin
         errors++;
         $display("FAIL missing_err: ERR=%0d LOCKED=%0d COL=%0d ROW=%0d expected 1/0/%0d/6",
                  sif.SYNC_ERR, sif.LOCKED, sif.COL, sif.ROW, HS);
      end
      step();
      checks++;
      if (sif.SYNC_ERR !== 1'b0 || sif.H_SYNC_O !== 1'b1) begin
         errors++;
         $display("FAIL missing_err_width: ERR=%0d H_SYNC_O=%0d expected 0/1", sif.SYNC_ERR, sif.H_SYNC_O);
      end
      n = 0; errs = 0;
      while (gr == 6 && n < HT) begin step(); n++; if (sif.SYNC_ERR === 1'b1) errs++; end
      mod_en = 0;
      n = 0;
      while (sif.H_SYNC_O !== 1'b0 && n < 2 * HT) begin step(); n++; if (sif.SYNC_ERR === 1'b1) errs++; end
      checks++;
      if (sif.H_SYNC_O !== 1'b0 || sif.COL !== 10'(HS) || sif.LOCKED !== 1'b0) begin
         errors++;
         $display("FAIL missing_h_realign: H_SYNC_O=%0d COL=%0d LOCKED=%0d expected 0/%0d/0",
                  sif.H_SYNC_O, sif.COL, sif.LOCKED, HS);
      end
      n = 0;
      while (sif.LOCKED !== 1'b1 && n < 2 * FT) begin
         step(); n++;
         if (sif.SYNC_ERR === 1'b1) errs++;
      end
      checks++;
      if (sif.LOCKED !== 1'b1 || sif.ROW !== 10'(VS) || errs !== 0) begin
         errors++;
         $display("FAIL missing_relock: LOCKED=%0d ROW=%0d extra_errs=%0d expected 1/%0d/0",
                  sif.LOCKED, sif.ROW, errs, VS);
      end
   endtask

   task automatic test_reset_midframe();
      int n, errs;
      n = 0;
      while (!(sif.ROW === 10'd8 && sif.COL === 10'd10) && n < 2 * FT) begin step(); n++; end
      checks++;
      if (sif.LOCKED !== 1'b1 || sif.ROW !== 10'd8) begin
         errors++;
         $display("FAIL midframe_setup: LOCKED=%0d ROW=%0d expected 1/8", sif.LOCKED, sif.ROW);
      end
      RST_N = 1'b0;
      #2;   // well before the next clock edge
      checks++;
      if (sif.COL !== 10'd0 || sif.ROW !== 10'd0 ||
          {sif.ACTIVE, sif.LOCKED, sif.FRAME_START, sif.SYNC_ERR, sif.H_SYNC_O, sif.V_SYNC_O} !== 6'b000011) begin
         errors++;
         $display("FAIL async_reset: COL=%0d ROW=%0d flags=%b expected 0/0/000011", sif.COL, sif.ROW,
                  {sif.ACTIVE, sif.LOCKED, sif.FRAME_START, sif.SYNC_ERR, sif.H_SYNC_O, sif.V_SYNC_O});
      end
      step();
      step();
      checks++;
      if (sif.COL !== 10'd0 || sif.LOCKED !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: COL=%0d LOCKED=%0d expected 0/0", sif.COL, sif.LOCKED);
      end
      RST_N = 1'b1;
      n = 0; errs = 0;
      while (sif.LOCKED !== 1'b1 && n < FT) begin
         step(); n++;
         if (sif.SYNC_ERR === 1'b1) errs++;
      end
      checks++;
      if (sif.LOCKED !== 1'b1 || sif.ROW !== 10'(VS) || errs !== 0) begin
         errors++;
         $display("FAIL midframe_relock: LOCKED=%0d ROW=%0d errs=%0d clocks=%0d expected 1/%0d/0",
                  sif.LOCKED, sif.ROW, errs, n, VS);
      end
   endtask

   initial begin
      sif.H_pulse = 1'b1;
      sif.V_pulse = 1'b1;
      test_reset();
      test_acquire();
      test_wrap();
      test_line_stretch();
      test_missing_pulse();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sync_to_count.md
# sync_to_count

Consumes the active-low H_pulse/V_pulse pair produced by the VGA sync generator and rebuilds the column/row pixel coordinates from it. Also produces an active-video qualifier, sync outputs re-timed to the coordinates, and lock/error status. Sits directly downstream of the sync generator and feeds the pixel/pattern stage. A three-state lock machine checks every sync edge against the free-running counters.

## Interface
Parameters:
- H_TOTAL, 800, clocks per line
- V_TOTAL, 525, lines per frame
- H_ACTIVE, 640, visible columns
- V_ACTIVE, 480, visible rows
- H_FRONT, 16, horizontal front porch; H sync starts at column H_ACTIVE+H_FRONT (656)
- V_FRONT, 10, vertical front porch; V sync starts at row V_ACTIVE+V_FRONT (490)

Ports:
- CLK  in  1  pixel clock, 25 MHz; same clock as the sync generator
- RST_N  in  1  asynchronous, active-low reset
- H_pulse  in  1  horizontal sync from the generator, active low
- V_pulse  in  1  vertical sync from the generator, active low
- COL  out  10  column coordinate, 0..H_TOTAL-1
- ROW  out  10  row coordinate, 0..V_TOTAL-1
- ACTIVE  out  1  high when COL<H_ACTIVE, ROW<V_ACTIVE and the machine is LOCKED
- H_SYNC_O  out  1  H_pulse delayed one clock, aligned with COL/ROW
- V_SYNC_O  out  1  V_pulse delayed one clock, aligned with COL/ROW
- LOCKED  out  1  machine is in the LOCKED state
- FRAME_START  out  1  one-cycle pulse when COL=0 and ROW=0 while LOCKED
- SYNC_ERR  out  1  one-cycle pulse on any lock violation

## Operation
- **Edge detect.** Registers h_d and v_d hold the previous samples of H_pulse and V_pulse.
  - hfall = h_d & ~H_pulse
  - vfall = v_d & ~V_pulse
- **COL update, in priority order:**
  - hfall: load H_ACTIVE+H_FRONT.
  - COL=H_TOTAL-1: load 0 (wrap).
  - otherwise: increment.
- **ROW update, in priority order:**
  - vfall: load V_ACTIVE+V_FRONT.
  - Column wrap with ROW=V_TOTAL-1: load 0.
  - Column wrap otherwise: increment.
  - Otherwise: hold.
  - Loads on edges happen in every state.
- **Predicted edges.**
  - hexp is true when the next free-running COL equals H_ACTIVE+H_FRONT.
  - vexp is true when, in the same cycle, COL wraps and the next free-running ROW equals V_ACTIVE+V_FRONT.
- **States:** UNLOCKED, H_ALIGNED, LOCKED.
  - UNLOCKED: hfall → H_ALIGNED.
  - H_ALIGNED: vfall → LOCKED. An hfall in this state only reloads COL.
  - LOCKED, early or misplaced edge: hfall with !hexp, or vfall with !vexp → SYNC_ERR, go to H_ALIGNED. The counters are reloaded by that edge.
  - LOCKED, missing edge: hexp with no hfall, or vexp with no vfall → SYNC_ERR, go to UNLOCKED. The counters keep free-running.
  - LOCKED, an H error and a V error in the same cycle: one SYNC_ERR pulse; the missing-edge case takes priority (go to UNLOCKED).
- **Widths.** All arithmetic is 10-bit unsigned. Parameters must satisfy H_TOTAL ≤ 1024 and V_TOTAL ≤ 1024.

## Timing
- **Reset (RST_N low), applied asynchronously, including mid-frame:**
  - COL=0, ROW=0
  - h_d=1, v_d=1
  - H_SYNC_O=1, V_SYNC_O=1
  - ACTIVE=0, LOCKED=0, FRAME_START=0, SYNC_ERR=0
  - state UNLOCKED
  - Leaving reset requires a fresh H edge and then a V edge to lock.
- **Alignment and latency.** All outputs are registered.
  - At the rising edge that first samples H_pulse=0, COL becomes 656 and H_SYNC_O becomes 0 in the same cycle.
  - V behaves the same way: ROW becomes 490 and V_SYNC_O becomes 0 together.
- **LOCKED and SYNC_ERR** are registered from the next-state decision. Both change in the cycle after the deciding edge is sampled.
- **ACTIVE** is computed from the next-state values of COL, ROW and the state, so it is aligned with COL/ROW.
  - It is low in the cycle the machine leaves LOCKED.
- **FRAME_START** is high exactly in the cycle COL=0 and ROW=0 with LOCKED=1.
- **Nominal 800×525 timing from a correct generator:**
  - LOCKED rises at the first V falling edge after the first H falling edge following reset.
  - SYNC_ERR then never asserts.

## Test plan
- **Reset values.** Hold RST_N=0 for 5 clocks → all outputs at their reset values, including H_SYNC_O=1 and V_SYNC_O=1. Release with H/V held high → COL counts 0,1,2…, ROW=0, LOCKED=0.
- **Acquisition with the real sync generator (40 ns clock).**
  - First H_SYNC_O=0 coincides with COL=656.
  - LOCKED=1 one clock after the first V falling edge, with ROW=490.
  - Next FRAME_START occurs 35×800 clocks later.
  - ACTIVE is high for exactly 307200 clocks per frame.
  - No SYNC_ERR over 3 frames.
- **Wrap.** At COL 799→0, ROW increments. At ROW=524, COL 799→0 gives ROW=0 and FRAME_START=1 for one clock.
- **Line stretch.** While LOCKED, delay one H falling edge by 4 clocks:
  - SYNC_ERR=1 for exactly one clock.
  - LOCKED=0 and ACTIVE=0.
  - COL reloads to 656 on the late edge.
  - LOCKED returns after the next V edge.
- **Missing pulse.** While LOCKED, suppress one H pulse → SYNC_ERR one clock at predicted COL=656, state UNLOCKED. Relock on the next H edge followed by the next V edge.
- **Reset mid-frame.** Pulse RST_N low for 2 clocks at ROW=200:
  - Outputs go to reset values asynchronously, without waiting for CLK.
  - After release, the block relocks within one frame with no SYNC_ERR.
